alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter_alu.sv | 46 ++++
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// Holds the opcode encodings, the datapath width and the arbiter FSM states.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Only add..xor are served; anything else completes as an error response.
  function automatic logic op_legal(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the consumer.
// The master side is the traffic source/sink; the slave side is the arbiter.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic              req0_valid;
  logic [3:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_ready;

  logic              req1_valid;
  logic [3:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_ready;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_r;
  logic              rsp_zero;
  logic              rsp_overflow;
  logic              rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_overflow, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_overflow, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU block: add/sub with carry-in, bitwise logic and shifts.
// Unrecognised opcodes yield a zero result that callers must not rely on.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cn,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] r,
  output logic              zero,
  output logic              overflow
);

  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  logic [DATA_W-1:0] cn_ext_s;

  assign cn_ext_s = {{(DATA_W-1){1'b0}}, cn};

  // Result, zero and signed-overflow flags.
  always_comb begin
    r        = {DATA_W{1'b0}};
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        r        = a + b + cn_ext_s;
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        r        = a - b - cn_ext_s;
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << shamt;
      OP_SRL:  r = a >> shamt;
      default: r = {DATA_W{1'b0}};
    endcase
    zero = (r == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrates, runs one operation at a time through
// the ALU and holds a registered response until the consumer takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_r_q, rsp_r_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant0_s, grant1_s;
  logic [DATA_W-1:0] alu_r_s;
  logic              alu_zero_unused;
  logic              alu_ovf_unused;
  logic              err_s;
  logic [DATA_W-1:0] result_s;
  logic              ovf_s;

  alu_arbiter_alu u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .cn       (1'b0),
    .shamt    (5'd0),
    .r        (alu_r_s),
    .zero     (alu_zero_unused),
    .overflow (alu_ovf_unused)
  );

  // Grant selection; ready is held low while reset is asserted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (FIXED_PRIO != 0) begin
          grant0_s = 1'b1;
        end else if (last_grant_q) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else if (bus.req0_valid) begin
        grant0_s = 1'b1;
      end else if (bus.req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Illegal opcodes bypass the ALU output, which is undefined for them.
  always_comb begin
    err_s    = !op_legal(op_q);
    result_s = err_s ? {DATA_W{1'b0}} : alu_r_s;
    case (op_q)
      OP_ADD:  ovf_s = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (result_s[DATA_W-1] != a_q[DATA_W-1]);
      OP_SUB:  ovf_s = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (result_s[DATA_W-1] != a_q[DATA_W-1]);
      default: ovf_s = 1'b0;
    endcase
  end

  // FSM next state, operand capture and response staging.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_r_d      = rsp_r_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant0_s || grant1_s) begin
          id_d         = grant1_s;
          last_grant_d = grant1_s;
          op_d         = grant1_s ? bus.req1_op : bus.req0_op;
          a_d          = grant1_s ? bus.req1_a  : bus.req0_a;
          b_d          = grant1_s ? bus.req1_b  : bus.req0_b;
          state_d      = EXEC;
        end else begin
          state_d      = IDLE;
        end
      end
      EXEC: begin
        rsp_id_d    = id_q;
        rsp_r_d     = result_s;
        rsp_zero_d  = (result_s == {DATA_W{1'b0}});
        rsp_ovf_d   = ovf_s;
        rsp_err_d   = err_s;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= 4'd0;
      a_q          <= {DATA_W{1'b0}};
      b_q          <= {DATA_W{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_r_q      <= {DATA_W{1'b0}};
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_r_q      <= rsp_r_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req0_ready   = grant0_s;
  assign bus.req1_ready   = grant1_s;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_r        = rsp_r_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority
// instance share the same stimulus; expected values are hand-computed.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        v0, v1, rsp_rdy;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  int          err_cnt;
  int          chk_cnt;

  alu_arbiter_if bus_rr();
  alu_arbiter_if bus_fp();

  assign bus_rr.req0_valid = v0;
  assign bus_rr.req0_op    = op0;
  assign bus_rr.req0_a     = a0;
  assign bus_rr.req0_b     = b0;
  assign bus_rr.req1_valid = v1;
  assign bus_rr.req1_op    = op1;
  assign bus_rr.req1_a     = a1;
  assign bus_rr.req1_b     = b1;
  assign bus_rr.rsp_ready  = rsp_rdy;

  assign bus_fp.req0_valid = v0;
  assign bus_fp.req0_op    = op0;
  assign bus_fp.req0_a     = a0;
  assign bus_fp.req0_b     = b0;
  assign bus_fp.req1_valid = v1;
  assign bus_fp.req1_op    = op1;
  assign bus_fp.req1_a     = a1;
  assign bus_fp.req1_b     = b1;
  assign bus_fp.rsp_ready  = rsp_rdy;

  alu_arbiter #(.FIXED_PRIO(0)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
  alu_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit id, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      v1 = v; op1 = op; a1 = a; b1 = b;
    end else begin
      v0 = v; op0 = op; a0 = a; b0 = b;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one op from an idle arbiter with rsp_ready high and check the response.
  task automatic single_op(input string tag, input bit id, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input logic exp_z,
                           input logic exp_o, input logic exp_e);
    int cyc;
    set_req(id, 1'b1, op, a, b);
    #1;
    check_eq({tag, ".ready"}, id ? bus_rr.req1_ready : bus_rr.req0_ready, 32'd1);
    @(negedge clk);
    if (id) v1 = 1'b0; else v0 = 1'b0;
    cyc = 1;
    while (!bus_rr.rsp_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, ".latency"}, cyc,                    32'd2);
    check_eq({tag, ".valid"},   bus_rr.rsp_valid,       32'd1);
    check_eq({tag, ".id"},      bus_rr.rsp_id,          {31'd0, id});
    check_eq({tag, ".r"},       bus_rr.rsp_r,           exp_r);
    check_eq({tag, ".zero"},    bus_rr.rsp_zero,        {31'd0, exp_z});
    check_eq({tag, ".ovf"},     bus_rr.rsp_overflow,    {31'd0, exp_o});
    check_eq({tag, ".err"},     bus_rr.rsp_err,         {31'd0, exp_e});
    @(negedge clk);
    check_eq({tag, ".done"},    bus_rr.rsp_valid,       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    err_cnt = 0;
    chk_cnt = 0;
    rst = 1'b1;
    rsp_rdy = 1'b1;
    set_req(1'b0, 1'b1, 4'd1, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 4'd1, 32'd0, 32'd0);

    // Reset state: outputs low even with a request pending.
    #1;
    check_eq("rst.ready0", bus_rr.req0_ready, 32'd0);
    check_eq("rst.valid",  bus_rr.rsp_valid,  32'd0);
    check_eq("rst.r",      bus_rr.rsp_r,      32'd0);
    v0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Simple add right after reset release.
    single_op("add5_7", 1'b0, 4'b0001, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);

    // Contention after reset: req0 wins first.
    do_reset();
    set_req(1'b0, 1'b1, 4'b0010, 32'd3, 32'd3);
    set_req(1'b1, 1'b1, 4'b0101, 32'hF0F0F0F0, 32'h0F0F0F0F);
    #1;
    check_eq("cont.ready0", bus_rr.req0_ready, 32'd1);
    check_eq("cont.ready1", bus_rr.req1_ready, 32'd0);
    @(negedge clk);
    v0 = 1'b0;
    #1;
    check_eq("cont.exec_ready1", bus_rr.req1_ready, 32'd0);
    @(negedge clk);
    check_eq("cont.id0",   bus_rr.rsp_id,   32'd0);
    check_eq("cont.r0",    bus_rr.rsp_r,    32'd0);
    check_eq("cont.zero0", bus_rr.rsp_zero, 32'd1);
    @(negedge clk);
    check_eq("cont.ready1b", bus_rr.req1_ready, 32'd1);
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    check_eq("cont.id1",   bus_rr.rsp_id,   32'd1);
    check_eq("cont.r1",    bus_rr.rsp_r,    32'hFFFFFFFF);
    check_eq("cont.zero1", bus_rr.rsp_zero, 32'd0);
    @(negedge clk);

    // Both held valid for four ops: round-robin vs fixed priority.
    do_reset();
    set_req(1'b0, 1'b1, 4'b0001, 32'd1, 32'd1);
    set_req(1'b1, 1'b1, 4'b0001, 32'd2, 32'd2);
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!bus_rr.rsp_valid && cyc < 10);
      check_eq($sformatf("rr.valid%0d", i), bus_rr.rsp_valid, 32'd1);
      check_eq($sformatf("rr.id%0d", i),    bus_rr.rsp_id,    (i % 2 == 0) ? 32'd0 : 32'd1);
      check_eq($sformatf("rr.r%0d", i),     bus_rr.rsp_r,     (i % 2 == 0) ? 32'd2 : 32'd4);
      check_eq($sformatf("fp.valid%0d", i), bus_fp.rsp_valid, 32'd1);
      check_eq($sformatf("fp.id%0d", i),    bus_fp.rsp_id,    32'd0);
    end
    v0 = 1'b0;
    v1 = 1'b0;
    @(negedge clk);

    // Signed overflow boundaries.
    single_op("ovf_add", 1'b0, 4'b0001, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1, 1'b0);
    single_op("ovf_sub", 1'b1, 4'b0010, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    single_op("and",     1'b0, 4'b0011, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 1'b0);

    // Illegal opcode with a stalled consumer and a pending competitor.
    rsp_rdy = 1'b0;
    set_req(1'b0, 1'b1, 4'b1111, 32'd1, 32'd2);
    #1;
    check_eq("ill.ready0", bus_rr.req0_ready, 32'd1);
    @(negedge clk);
    v0 = 1'b0;
    set_req(1'b1, 1'b1, 4'b0100, 32'h000000F0, 32'h0000000F);
    @(negedge clk);
    a0 = 32'hDEADBEEF;
    #1;
    check_eq("ill.valid", bus_rr.rsp_valid,    32'd1);
    check_eq("ill.err",   bus_rr.rsp_err,      32'd1);
    check_eq("ill.r",     bus_rr.rsp_r,        32'd0);
    check_eq("ill.zero",  bus_rr.rsp_zero,     32'd1);
    check_eq("ill.ovf",   bus_rr.rsp_overflow, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("stall%0d.valid", i),  bus_rr.rsp_valid,  32'd1);
      check_eq($sformatf("stall%0d.r", i),      bus_rr.rsp_r,      32'd0);
      check_eq($sformatf("stall%0d.err", i),    bus_rr.rsp_err,    32'd1);
      check_eq($sformatf("stall%0d.id", i),     bus_rr.rsp_id,     32'd0);
      check_eq($sformatf("stall%0d.ready1", i), bus_rr.req1_ready, 32'd0);
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    check_eq("ill.done",   bus_rr.rsp_valid,  32'd0);
    check_eq("ill.ready1", bus_rr.req1_ready, 32'd1);
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    check_eq("or.id", bus_rr.rsp_id, 32'd1);
    check_eq("or.r",  bus_rr.rsp_r,  32'h000000FF);
    check_eq("or.err", bus_rr.rsp_err, 32'd0);
    @(negedge clk);

    // Reset while a response is held; pending request served after release.
    rsp_rdy = 1'b0;
    set_req(1'b0, 1'b1, 4'b0001, 32'd2, 32'd3);
    @(negedge clk);
    v0 = 1'b0;
    set_req(1'b1, 1'b1, 4'b0010, 32'd10, 32'd4);
    @(negedge clk);
    check_eq("rr_resp.valid", bus_rr.rsp_valid, 32'd1);
    check_eq("rr_resp.r",     bus_rr.rsp_r,     32'd5);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst.valid",  bus_rr.rsp_valid,  32'd0);
    check_eq("arst.r",      bus_rr.rsp_r,      32'd0);
    check_eq("arst.ready1", bus_rr.req1_ready, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rsp_rdy = 1'b1;
    #1;
    check_eq("rel.valid",  bus_rr.rsp_valid,  32'd0);
    check_eq("rel.ready1", bus_rr.req1_ready, 32'd1);
    @(negedge clk);
    v1 = 1'b0;
    check_eq("rel.exec_valid", bus_rr.rsp_valid, 32'd0);
    @(negedge clk);
    check_eq("rel.id", bus_rr.rsp_id, 32'd1);
    check_eq("rel.r",  bus_rr.rsp_r,  32'd6);
    @(negedge clk);
    check_eq("rel.done", bus_rr.rsp_valid, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
